// File: rtl/dmem_unit.sv
// MEM-stage data memory with sub-word access, configurable read latency and misalignment reporting.
// Define DMEM_ERR_CNT_EN to build the saturating misalignment counter behind err_cnt.
module dmem_unit #(
    parameter int DEPTH_LOG2 = 14,
    parameter int READ_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic        req_jal,
    input  logic        req_regdst,
    output logic        ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_wnum,
    output logic        misalign,
    output logic [31:0] err_addr,
    output logic [15:0] err_cnt
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] p_data_q, p_data_d;
    logic [4:0]  p_wnum_q, p_wnum_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  wnum_q, wnum_d;
    logic        misalign_q, misalign_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  accept;
    logic                  mis;
    logic                  acc_load;
    logic                  acc_store;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [4:0]            req_wnum;
    logic [31:0]           ext_live;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Upper address bits are dropped so the memory wraps at 4*DEPTH bytes.
    assign word_idx  = req_addr[DEPTH_LOG2+1:2];
    assign ready     = (state_q != WAIT);
    assign accept    = req_valid & ready;
    assign acc_load  = accept & ~req_we & ~mis;
    assign acc_store = accept & req_we & ~mis;
    assign req_wnum  = req_jal ? 5'd31 : (req_regdst ? req_rd : req_rt);
    assign ext_live  = extend(mem[word_idx], req_size, req_unsigned, req_addr[1:0]);

    always_comb begin
        mis       = 1'b0;
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                mis       = req_addr[0];
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                mis = |req_addr[1:0];
                be  = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_data_d   = p_data_q;
        p_wnum_d   = p_wnum_q;
        rdata_d    = rdata_q;
        wnum_d     = wnum_q;
        misalign_d = accept & mis;
        err_addr_d = (accept & mis) ? req_addr : err_addr_q;
        if (state_q == WAIT) begin
            if (cnt_q == 3'd1) begin
                state_d = RESP;
                rdata_d = p_data_q;
                wnum_d  = p_wnum_q;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end else begin
            // IDLE or RESP: stores and misaligned requests fall back to IDLE.
            state_d = IDLE;
            if (acc_load) begin
                p_data_d = ext_live;
                p_wnum_d = req_wnum;
                if (READ_LAT == 1) begin
                    state_d = RESP;
                    rdata_d = ext_live;
                    wnum_d  = req_wnum;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            p_data_q   <= 32'd0;
            p_wnum_q   <= 5'd0;
            rdata_q    <= 32'd0;
            wnum_q     <= 5'd0;
            misalign_q <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_data_q   <= p_data_d;
            p_wnum_q   <= p_wnum_d;
            rdata_q    <= rdata_d;
            wnum_q     <= wnum_d;
            misalign_q <= misalign_d;
            err_addr_q <= err_addr_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (acc_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_wnum  = wnum_q;
    assign misalign  = misalign_q;
    assign err_addr  = err_addr_q;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (misalign_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: three instances cover READ_LAT 1/3/2 and a small wrapping depth.
module tb_dmem_unit;

    logic        clk;
    logic        rst_n        [3];
    logic        req_valid    [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic [4:0]  req_rt       [3];
    logic [4:0]  req_rd       [3];
    logic        req_jal      [3];
    logic        req_regdst   [3];
    logic        ready        [3];
    logic        rsp_valid    [3];
    logic [31:0] rsp_rdata    [3];
    logic [4:0]  rsp_wnum     [3];
    logic        misalign     [3];
    logic [31:0] err_addr     [3];
    logic [15:0] err_cnt      [3];

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_unit #(.DEPTH_LOG2(14), .READ_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_rt(req_rt[0]), .req_rd(req_rd[0]), .req_jal(req_jal[0]),
        .req_regdst(req_regdst[0]), .ready(ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_wnum(rsp_wnum[0]), .misalign(misalign[0]),
        .err_addr(err_addr[0]), .err_cnt(err_cnt[0])
    );

    dmem_unit #(.DEPTH_LOG2(4), .READ_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_rt(req_rt[1]), .req_rd(req_rd[1]), .req_jal(req_jal[1]),
        .req_regdst(req_regdst[1]), .ready(ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_wnum(rsp_wnum[1]), .misalign(misalign[1]),
        .err_addr(err_addr[1]), .err_cnt(err_cnt[1])
    );

    dmem_unit #(.DEPTH_LOG2(4), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
        .req_size(req_size[2]), .req_unsigned(req_unsigned[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_rt(req_rt[2]), .req_rd(req_rd[2]), .req_jal(req_jal[2]),
        .req_regdst(req_regdst[2]), .ready(ready[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_wnum(rsp_wnum[2]), .misalign(misalign[2]),
        .err_addr(err_addr[2]), .err_cnt(err_cnt[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rt,
                           input logic [4:0] rd, input logic jal, input logic rdst);
        req_valid[i]    = 1'b1;
        req_we[i]       = we;
        req_size[i]     = sz;
        req_unsigned[i] = uns;
        req_addr[i]     = a;
        req_wdata[i]    = wd;
        req_rt[i]       = rt;
        req_rd[i]       = rd;
        req_jal[i]      = jal;
        req_regdst[i]   = rdst;
    endtask

    task automatic clr_req(input int i);
        req_valid[i]    = 1'b0;
        req_we[i]       = 1'b0;
        req_size[i]     = 2'd0;
        req_unsigned[i] = 1'b0;
        req_addr[i]     = 32'd0;
        req_wdata[i]    = 32'd0;
        req_rt[i]       = 5'd0;
        req_rd[i]       = 5'd0;
        req_jal[i]      = 1'b0;
        req_regdst[i]   = 1'b0;
    endtask

    task automatic do_store(input int i, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        @(negedge clk);
        set_req(i, 1'b1, sz, 1'b0, a, wd, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_req(i);
    endtask

    // Issues a load from IDLE and returns at the negedge where rsp_valid is seen (lat=-1 on timeout).
    task automatic do_load(input int i, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [4:0] rt, input logic [4:0] rd, input logic jal,
                           input logic rdst, output logic [31:0] data, output logic [4:0] wnum,
                           output int lat);
        int c;
        @(negedge clk);
        set_req(i, 1'b0, sz, uns, a, 32'd0, rt, rd, jal, rdst);
        @(posedge clk);
        @(negedge clk);
        clr_req(i);
        lat = -1;
        c   = 1;
        while (lat < 0 && c <= 8) begin
            if (rsp_valid[i] === 1'b1) begin
                lat = c;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        data = rsp_rdata[i];
        wnum = rsp_wnum[i];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            clr_req(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ready[i], rsp_valid[i], misalign[i]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: got ready/rsp/mis=%b%b%b want 100",
                         i, ready[i], rsp_valid[i], misalign[i]);
            end
            n_cmp++;
            if ({rsp_rdata[i], rsp_wnum[i], err_addr[i], err_cnt[i]} !== 85'd0) begin
                n_fail++;
                $display("FAIL reset_regs dut%0d: got rdata=%h wnum=%0d err_addr=%h err_cnt=%0d want all 0",
                         i, rsp_rdata[i], rsp_wnum[i], err_addr[i], err_cnt[i]);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] d;
        logic [4:0]  w;
        int          lat;
        do_store(0, 2'd2, 32'h10, 32'h12345678);
        do_load(0, 2'd2, 1'b0, 32'h10, 5'd5, 5'd20, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (lat !== 1) begin n_fail++; $display("FAIL lw_latency: got %0d want 1", lat); end
        n_cmp++;
        if (d !== 32'h12345678) begin n_fail++; $display("FAIL lw_data: got %h want 12345678", d); end
        n_cmp++;
        if (w !== 5'd5) begin n_fail++; $display("FAIL lw_wnum_rt: got %0d want 5", w); end
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid[0], rsp_rdata[0]} !== {1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL rsp_hold: got valid=%b data=%h want 0/12345678", rsp_valid[0], rsp_rdata[0]);
        end
    endtask

    task automatic test_subword();
        logic [31:0] d;
        logic [4:0]  w;
        int          lat;
        do_store(0, 2'd0, 32'h13, 32'hAAAAAA80);
        do_load(0, 2'd0, 1'b0, 32'h13, 5'd6, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'hFFFFFF80 || lat !== 1) begin
            n_fail++; $display("FAIL lb_sign: got %h lat %0d want ffffff80 lat 1", d, lat);
        end
        do_load(0, 2'd0, 1'b1, 32'h13, 5'd6, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zero: got %h want 00000080", d); end
        do_load(0, 2'd2, 1'b0, 32'h10, 5'd6, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'h80345678) begin n_fail++; $display("FAIL sb_lane3: got %h want 80345678", d); end
    endtask

    task automatic test_half_dest();
        logic [31:0] d;
        logic [4:0]  w;
        int          lat;
        do_store(0, 2'd1, 32'h22, 32'h1234BEEF);
        do_load(0, 2'd1, 1'b0, 32'h22, 5'd3, 5'd9, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'hFFFFBEEF || w !== 5'd3) begin
            n_fail++; $display("FAIL lh_sign: got %h wnum %0d want ffffbeef wnum 3", d, w);
        end
        do_load(0, 2'd1, 1'b1, 32'h22, 5'd3, 5'd9, 1'b1, 1'b1, d, w, lat);
        n_cmp++;
        if (d !== 32'h0000BEEF || w !== 5'd31) begin
            n_fail++; $display("FAIL lhu_jal: got %h wnum %0d want 0000beef wnum 31", d, w);
        end
        do_load(0, 2'd1, 1'b1, 32'h22, 5'd3, 5'd9, 1'b0, 1'b1, d, w, lat);
        n_cmp++;
        if (w !== 5'd9) begin n_fail++; $display("FAIL wnum_regdst: got %0d want 9", w); end
        do_load(0, 2'd0, 1'b0, 32'h23, 5'd3, 5'd9, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb_lane3_half: got %h want ffffffbe", d); end
        do_load(0, 2'd0, 1'b1, 32'h22, 5'd3, 5'd9, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'h000000EF) begin n_fail++; $display("FAIL lbu_lane2: got %h want 000000ef", d); end
    endtask

    task automatic test_back_to_back();
        do_store(1, 2'd2, 32'h0, 32'hA1A2A3A4);
        do_store(1, 2'd2, 32'h4, 32'hB1B2B3B4);
        @(negedge clk);
        set_req(1, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 5'd1, 5'd0, 1'b0, 1'b0);
        n_cmp++;
        if (ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b want 1", ready[1]); end
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, 5'd2, 5'd0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({ready[1], rsp_valid[1]} !== 2'b00) begin
                n_fail++; $display("FAIL b2b_wait1 c%0d: got ready/rsp=%b%b want 00", c, ready[1], rsp_valid[1]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if ({ready[1], rsp_valid[1], rsp_rdata[1], rsp_wnum[1]} !== {2'b11, 32'hA1A2A3A4, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_rsp1: got ready=%b rsp=%b data=%h wnum=%0d want 1 1 a1a2a3a4 1",
                     ready[1], rsp_valid[1], rsp_rdata[1], rsp_wnum[1]);
        end
        @(posedge clk);
        @(negedge clk);
        clr_req(1);
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({ready[1], rsp_valid[1]} !== 2'b00) begin
                n_fail++; $display("FAIL b2b_wait2 c%0d: got ready/rsp=%b%b want 00", c, ready[1], rsp_valid[1]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if ({rsp_valid[1], rsp_rdata[1], rsp_wnum[1]} !== {1'b1, 32'hB1B2B3B4, 5'd2}) begin
            n_fail++;
            $display("FAIL b2b_rsp2: got rsp=%b data=%h wnum=%0d want 1 b1b2b3b4 2",
                     rsp_valid[1], rsp_rdata[1], rsp_wnum[1]);
        end
        @(negedge clk);
        n_cmp++;
        if ({ready[1], rsp_valid[1]} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_end: got ready/rsp=%b%b want 10", ready[1], rsp_valid[1]);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        logic [4:0]  w;
        int          lat;
        logic [15:0] exp_cnt;
`ifdef DMEM_ERR_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        do_store(0, 2'd2, 32'h20, 32'h11223344);
        @(negedge clk);
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h6, 32'd0, 5'd4, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({misalign[0], rsp_valid[0], err_addr[0]} !== {2'b10, 32'h6}) begin
            n_fail++; $display("FAIL mis_lw6: got mis=%b rsp=%b err_addr=%h want 1 0 6",
                               misalign[0], rsp_valid[0], err_addr[0]);
        end
        set_req(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, 5'd0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({misalign[0], err_addr[0]} !== {1'b1, 32'h21}) begin
            n_fail++; $display("FAIL mis_sh21: got mis=%b err_addr=%h want 1 21", misalign[0], err_addr[0]);
        end
        set_req(0, 1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 5'd4, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_req(0);
        n_cmp++;
        if ({misalign[0], err_addr[0]} !== {1'b1, 32'h40}) begin
            n_fail++; $display("FAIL mis_size3: got mis=%b err_addr=%h want 1 40", misalign[0], err_addr[0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({misalign[0], err_addr[0]} !== {1'b0, 32'h40}) begin
            n_fail++; $display("FAIL mis_pulse_end: got mis=%b err_addr=%h want 0 40", misalign[0], err_addr[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (err_cnt[0] !== exp_cnt) begin
            n_fail++; $display("FAIL err_cnt: got %0d want %0d", err_cnt[0], exp_cnt);
        end
        do_load(0, 2'd2, 1'b0, 32'h20, 5'd4, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'h11223344) begin n_fail++; $display("FAIL mis_no_write: got %h want 11223344", d); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] d;
        logic [4:0]  w;
        int          lat;
        int          seen;
        do_store(2, 2'd2, 32'h40, 32'hCAFEF00D);
        do_load(2, 2'd2, 1'b0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'hCAFEF00D || w !== 5'd7 || lat !== 2) begin
            n_fail++; $display("FAIL wrap_lw0: got %h wnum %0d lat %0d want cafef00d 7 2", d, w, lat);
        end
        do_load(2, 2'd1, 1'b1, 32'h42, 5'd7, 5'd0, 1'b0, 1'b0, d, w, lat);
        n_cmp++;
        if (d !== 32'h0000CAFE) begin n_fail++; $display("FAIL wrap_lhu42: got %h want 0000cafe", d); end
        @(negedge clk);
        set_req(2, 1'b0, 2'd1, 1'b0, 32'h3, 32'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_req(2);
        n_cmp++;
        if ({misalign[2], err_addr[2]} !== {1'b1, 32'h3}) begin
            n_fail++; $display("FAIL mis_lh3: got mis=%b err_addr=%h want 1 3", misalign[2], err_addr[2]);
        end
        @(negedge clk);
        set_req(2, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 5'd7, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clr_req(2);
        n_cmp++;
        if (ready[2] !== 1'b0) begin n_fail++; $display("FAIL midload_wait: got ready=%b want 0", ready[2]); end
        rst_n[2] = 1'b0;
        #1;
        n_cmp++;
        if ({ready[2], rsp_valid[2], misalign[2], rsp_rdata[2], rsp_wnum[2], err_addr[2], err_cnt[2]}
            !== {3'b100, 85'd0}) begin
            n_fail++;
            $display("FAIL midload_reset: got ready=%b rsp=%b mis=%b data=%h wnum=%0d err_addr=%h cnt=%0d want 1 0 0 0 0 0 0",
                     ready[2], rsp_valid[2], misalign[2], rsp_rdata[2], rsp_wnum[2], err_addr[2], err_cnt[2]);
        end
        @(negedge clk);
        rst_n[2] = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid[2] !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_fail++; $display("FAIL midload_no_rsp: got %0d rsp cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_half_dest();
        test_back_to_back();
        test_misalign();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
